// File: rtl/swi_pkg.sv
// Shared defaults and helpers for the switch reader: bus width, debounce length,
// switch-bus type and debounce counter width.
package swi_pkg;

  localparam int NBITS_DEF           = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef logic [NBITS_DEF-1:0] swi_t;

  // Counter must hold 0..n-1; a one-cycle debounce still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNTW = cnt_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, consecutive-difference counter,
// debounced level and registered rise/fall strobes.
module debounce_bit
  import swi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic stable_nxt,
  output logic chg_nxt
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable     = stable_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  // Next-state view lets the event register update on the same edge as the strobes.
  assign stable_nxt = stable_d;
  assign chg_nxt    = rise_d | fall_d;

endmodule

// File: rtl/swi_reader.sv
// Switch bus reader: per-bit debounce plus a valid/ready change-event register
// that merges further changes into a pending event and flags the overrun.
module swi_reader
  import swi_pkg::*;
#(
  parameter int NBITS           = NBITS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] SWI,
  output logic [NBITS-1:0] swi_stable,
  output logic [NBITS-1:0] swi_rise,
  output logic [NBITS-1:0] swi_fall,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [NBITS-1:0] evt_data,
  output logic [NBITS-1:0] evt_mask,
  output logic             evt_overrun
);

  logic [NBITS-1:0] stable_nxt;
  logic [NBITS-1:0] chg_bits;

  for (genvar b = 0; b < NBITS; b++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk       (clk_2),
      .rst       (reset),
      .din       (SWI[b]),
      .stable    (swi_stable[b]),
      .rise      (swi_rise[b]),
      .fall      (swi_fall[b]),
      .stable_nxt(stable_nxt[b]),
      .chg_nxt   (chg_bits[b])
    );
  end

  logic             valid_q, valid_d;
  logic [NBITS-1:0] data_q, data_d;
  logic [NBITS-1:0] mask_q, mask_d;
  logic             ovr_q, ovr_d;
  logic             xfer;

  assign xfer = valid_q & evt_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    mask_d  = mask_q;
    ovr_d   = ovr_q;
    if (|chg_bits) begin
      data_d = stable_nxt;
      if (!valid_q || xfer) begin
        valid_d = 1'b1;
        mask_d  = chg_bits;
        ovr_d   = 1'b0;
      end else begin
        mask_d = mask_q | chg_bits;
        ovr_d  = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
      mask_d  = '0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      ovr_q   <= ovr_d;
    end
  end

  assign evt_valid   = valid_q;
  assign evt_data    = data_q;
  assign evt_mask    = mask_q;
  assign evt_overrun = ovr_q;

endmodule

// File: tb/tb_swi_reader.sv
// Bench for swi_reader: directed scenarios plus randomized switch activity,
// checked every cycle against a sample-history reference model.
module tb_swi_reader;
  import swi_pkg::*;

  localparam int DEB = 4;

  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  swi_t SWI   = '0;
  logic evt_ready = 1'b0;
  swi_t swi_stable, swi_rise, swi_fall, evt_data, evt_mask;
  logic evt_valid, evt_overrun;

  swi_reader #(.NBITS(8), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_2(clk_2), .reset(reset), .SWI(SWI),
    .swi_stable(swi_stable), .swi_rise(swi_rise), .swi_fall(swi_fall),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_mask(evt_mask), .evt_overrun(evt_overrun)
  );

  always #5 clk_2 = ~clk_2;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: raw SWI samples per edge; a bit flips when the D samples that
  // reached the synchroniser output on the last D edges all differ from it.
  swi_t m_hist[$];
  swi_t m_stable, m_rise, m_fall, m_data, m_mask;
  logic m_valid, m_ovr;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i <= DEB; i++) m_hist.push_back('0);
    m_stable = '0; m_rise = '0; m_fall = '0;
    m_data = '0; m_mask = '0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_edge();
    swi_t chg, nst;
    logic acc, xfer;
    if (reset) return;
    chg = '0;
    nst = m_stable;
    for (int b = 0; b < 8; b++) begin
      acc = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (m_hist[j][b] == m_stable[b]) acc = 1'b0;
      if (acc) begin
        nst[b] = ~m_stable[b];
        chg[b] = 1'b1;
      end
    end
    m_rise = chg & nst;
    m_fall = chg & ~nst;
    xfer = m_valid && evt_ready;
    if (chg != 0) begin
      m_data = nst;
      if (!m_valid || xfer) begin
        m_valid = 1'b1; m_mask = chg; m_ovr = 1'b0;
      end else begin
        m_mask = m_mask | chg; m_ovr = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0; m_mask = '0; m_ovr = 1'b0;
    end
    m_stable = nst;
    m_hist.push_back(SWI);
    void'(m_hist.pop_front());
  endtask

  task automatic check_all();
    chk("stable", swi_stable, m_stable);
    chk("rise", swi_rise, m_rise);
    chk("fall", swi_fall, m_fall);
    chk("valid", 8'(evt_valid), 8'(m_valid));
    chk("data", evt_data, m_data);
    chk("mask", evt_mask, m_mask);
    chk("overrun", 8'(evt_overrun), 8'(m_ovr));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_2);
      model_edge();
      @(negedge clk_2);
      check_all();
    end
  endtask

  // Asserts reset mid-cycle, checks outputs clear without an edge, releases on a negedge.
  task automatic do_reset(input swi_t sw);
    #2;
    reset = 1'b1;
    SWI = sw;
    #1;
    model_reset();
    chk("rst_stable", swi_stable, 8'h00);
    chk("rst_rise", swi_rise, 8'h00);
    chk("rst_valid", 8'(evt_valid), 8'h00);
    chk("rst_mask", evt_mask, 8'h00);
    chk("rst_data", evt_data, 8'h00);
    chk("rst_ovr", 8'(evt_overrun), 8'h00);
    @(posedge clk_2);
    @(negedge clk_2);
    reset = 1'b0;
  endtask

  initial begin
    swi_t v;
    int hold;
    model_reset();
    repeat (2) @(negedge clk_2);
    reset = 1'b0;
    step(2);

    // Reset with all switches on, then first acceptance at the sixth edge
    do_reset(8'hFF);
    step(5);
    chk("pre_accept_stable", swi_stable, 8'h00);
    step(1);
    chk("e5_stable", swi_stable, 8'hFF);
    chk("e5_rise", swi_rise, 8'hFF);
    chk("e5_mask", evt_mask, 8'hFF);
    step(1);
    chk("rise_one_cycle", swi_rise, 8'h00);

    // Glitch rejection
    do_reset(8'h00);
    SWI = 8'h01; step(3);
    SWI = 8'h00; step(8);
    chk("glitch_stable", swi_stable, 8'h00);
    chk("glitch_valid", 8'(evt_valid), 8'h00);

    // Latency and fall
    SWI = 8'h01; step(8);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    SWI = 8'h00; step(5);
    chk("fall_not_yet", swi_fall, 8'h00);
    step(1);
    chk("fall_pulse", swi_fall, 8'h01);
    chk("fall_data", evt_data, 8'h00);
    chk("fall_mask", evt_mask, 8'h01);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;

    // Overrun merge
    SWI = 8'h04; step(6);
    SWI = 8'h24; step(6);
    chk("ovr_mask", evt_mask, 8'h24);
    chk("ovr_flag", 8'(evt_overrun), 8'h01);
    chk("ovr_data", evt_data, 8'h24);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    chk("ovr_clr_valid", 8'(evt_valid), 8'h00);
    chk("ovr_clr_mask", evt_mask, 8'h00);
    chk("ovr_clr_flag", 8'(evt_overrun), 8'h00);

    // Accept and change on the same edge
    SWI = 8'h20; step(6);
    SWI = 8'hA0; step(5);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    chk("simul_valid", 8'(evt_valid), 8'h01);
    chk("simul_mask", evt_mask, 8'h80);
    chk("simul_ovr", 8'(evt_overrun), 8'h00);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;

    // Reset during a count
    SWI = 8'hA8; step(4);
    do_reset(8'hA8);
    step(5);
    chk("rstcnt_hold", swi_stable, 8'h00);
    step(1);
    chk("rstcnt_accept", swi_stable, 8'hA8);

    // Randomized activity
    for (int p = 0; p < 300; p++) begin
      v = SWI;
      v[$urandom_range(7, 0)] ^= 1'b1;
      if ($urandom_range(3, 0) == 0) v[$urandom_range(7, 0)] ^= 1'b1;
      SWI = v;
      hold = $urandom_range(8, 1);
      for (int c = 0; c < hold; c++) begin
        evt_ready = ($urandom_range(2, 0) == 0);
        step(1);
      end
      if ($urandom_range(40, 0) == 0) do_reset(SWI);
    end
    evt_ready = 1'b0;
    step(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/swi_reader.md
# swi_reader

Input-side counterpart to the display outputs of the board top level. It samples the raw `SWI` switch bus, synchronises and debounces every bit independently, and presents a clean level, single-cycle rise/fall strobes, and a valid/ready change-event register. Sits between the board pins and any logic that must react to switch changes, such as processor I/O or LCD test harnesses.

## Interface
- `NBITS` — default 8 — width of the switch bus; matches `NBITS_TOP`.
- `DEBOUNCE_CYCLES` — default 4 — consecutive cycles a synchronised bit must differ from its stable value before it is accepted; legal range ≥ 1.

- `clk_2` — in — 1 — single system clock.
- `reset` — in — 1 — asynchronous, active-high reset.
- `SWI` — in — NBITS — raw, asynchronous switch levels.
- `swi_stable` — out — NBITS — debounced switch levels.
- `swi_rise` — out — NBITS — one-cycle pulse per bit on an accepted 0→1 change.
- `swi_fall` — out — NBITS — one-cycle pulse per bit on an accepted 1→0 change.
- `evt_valid` — out — 1 — a change event is pending.
- `evt_ready` — in — 1 — consumer accepts the pending event.
- `evt_data` — out — NBITS — `swi_stable` snapshot for the pending event.
- `evt_mask` — out — NBITS — bits that changed since the last accepted event.
- `evt_overrun` — out — 1 — more than one change set was merged into the pending event.

## Operation
- **Reset:** asynchronous. All synchroniser flops, `swi_stable`, counters, `swi_rise`, `swi_fall`, `evt_valid`, `evt_data`, `evt_mask` and `evt_overrun` go to 0. Reset takes effect at any time, including mid-count; no pending event survives it.
- **Synchroniser:** two flops per bit, `sync1 <= SWI` and `sync2 <= sync1`.
- **Per-bit debounce (`cnt`, width `$clog2(DEBOUNCE_CYCLES)`, minimum 1):**
  - If `sync2 == stable`, then `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`, then `stable <= sync2`, `cnt <= 0`, and the rise or fall pulse is asserted for that bit.
  - Else `cnt <= cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles resets `cnt` and produces no output change.
- **Strobes:** `swi_rise` and `swi_fall` are registered. Each is high for exactly one cycle, aligned with the `swi_stable` update. They never both assert on the same bit in the same cycle.
- **Event register.** Let `chg` = OR of all rise/fall pulses being generated at an edge.
  - **Handshake:** a transfer occurs when `evt_valid && evt_ready`. After a transfer, `evt_valid <= 0`, `evt_mask <= 0` and `evt_overrun <= 0`, unless `chg` occurs at the same edge.
  - **Change with no event pending, or with a transfer at the same edge:** `evt_valid <= 1`, `evt_data <= new stable`, `evt_mask <= changed bits`, `evt_overrun <= 0`.
  - **Change while an event is pending and not accepted:** `evt_data <= new stable`, `evt_mask <= evt_mask | changed bits`, `evt_overrun <= 1`.
  - **Stability:** `evt_valid` never drops without a transfer. `evt_data` and `evt_mask` change while valid only through the merge rule above.

## Timing
- Let E0 be the first `clk_2` edge that samples a new `SWI` level.
  - `sync2` updates at E1.
  - `swi_stable`, the strobes and `evt_valid` update at edge E(1+DEBOUNCE_CYCLES). With the default value this is E5, a latency of 5 edges.
- Release of `SWI` follows the same latency.
- `evt_ready` is sampled only at the clock edge. A combinational `evt_ready` tied high gives `evt_valid` high for exactly one cycle per change.
- A bit that changes again before acceptance produces a new strobe. It is merged into the pending event, per the event-register rule.

## Structure
- **Shared package `swi_pkg`:**
  - `NBITS`, `DEBOUNCE_CYCLES` defaults.
  - `swi_t` = `logic [NBITS-1:0]`.
  - Counter width constant `CNTW`.
- **Sub-module `debounce_bit`:** one instance per bit.
  - Contains the synchroniser, counter, stable flop and rise/fall flops.
  - Instantiated in a generate loop.
- The event register and handshake logic live in `swi_reader`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`.
- **Reset:** assert `reset` mid-cycle with `SWI = 8'hFF`. All outputs are 0 immediately, without waiting for a clock edge. Release reset and hold `SWI`. At E5 `swi_stable = 8'hFF`, `swi_rise = 8'hFF` for 1 cycle, `evt_mask = 8'hFF`.
- **Glitch rejection:** set `SWI[0]` to 1 for 3 cycles, then back to 0. `swi_stable` stays `8'h00`, with no strobes and no `evt_valid`.
- **Latency and fall:** from stable `8'h01`, drive `SWI = 8'h00` before E0. `swi_fall[0]` pulses at E5. `evt_data = 8'h00`, `evt_mask = 8'h01`.
- **Overrun merge:** hold `evt_ready = 0` and toggle bit 2, then bit 5 (each held 6 cycles). `evt_mask = 8'h24`, `evt_overrun = 1`, `evt_data` shows the latest level. Pulse `evt_ready` and check that `evt_valid`, `evt_mask` and `evt_overrun` all clear.
- **Simultaneous accept and change:** time `evt_ready` to the edge at which bit 7 is accepted. `evt_valid` stays 1, `evt_mask = 8'h80`, `evt_overrun = 0`.
- **Reset during a count:** assert `reset` while bit 3 is at `cnt = 2`. After release, a fresh 4-cycle count is required before bit 3 is accepted.
